// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM controller slice.
// Imported by the port arbiter and its round-robin sub-module.
package sram_ctrl_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    typedef struct packed {
        logic     vld;
        port_id_t id;
    } rd_tag_t;

    localparam int RSP_LATENCY = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a last-grant pointer.
// The pointer moves only when a grant is issued; after reset port A is favoured.
module rr_arb2
    import sram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o
);

    port_id_t last_q;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_q == PORT_A) ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

    // NOTE: sequential state is always updated with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= PORT_B;
        end else if (|grant_o) begin
            last_q <= grant_o[1] ? PORT_B : PORT_A;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM macro between requesters A and B, with an optional
// zero-fill after reset and a fixed two-cycle tagged read-response path.
module sram_port_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 7,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_rdata,

    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_rdata,

    output logic                  init_done,

    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = {ADDR_WIDTH{1'b1}};
    localparam ctrl_state_t           RESET_STATE = CLEAR_ON_RESET ? INIT : RUN;

    ctrl_state_t                     state_q;
    logic [ADDR_WIDTH-1:0]           clr_cnt_q;
    logic [ADDR_WIDTH-1:0]           addr_q;
    logic [DATA_WIDTH-1:0]           din_q;
    rd_tag_t [RSP_LATENCY-1:0]       tag_q;
    rd_tag_t                         tag_d;
    logic [DATA_WIDTH-1:0]           a_rdata_q;
    logic [DATA_WIDTH-1:0]           b_rdata_q;

    logic                            run;
    logic [1:0]                      req;
    logic [1:0]                      grant;
    logic                            sel_b;
    logic                            sel_we;
    logic [ADDR_WIDTH-1:0]           sel_addr;
    logic [DATA_WIDTH-1:0]           sel_din;
    logic                            csb_d;
    logic                            web_d;
    logic [ADDR_WIDTH-1:0]           addr_d;
    logic [DATA_WIDTH-1:0]           din_d;

    // Gating with rst_n keeps every output at its idle value for the whole reset pulse.
    assign run = (state_q == RUN) && rst_n;
    assign req = {b_req_valid, a_req_valid} & {2{run}};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req),
        .grant_o (grant)
    );

    assign a_req_ready = grant[0];
    assign b_req_ready = grant[1];
    assign init_done   = run;

    assign sel_b    = grant[1];
    assign sel_we   = sel_b ? b_req_we    : a_req_we;
    assign sel_addr = sel_b ? b_req_addr  : a_req_addr;
    assign sel_din  = sel_b ? b_req_wdata : a_req_wdata;

    always_comb begin
        csb_d  = 1'b1;
        web_d  = 1'b1;
        addr_d = addr_q;
        din_d  = din_q;
        if (!rst_n) begin
            addr_d = '0;
            din_d  = '0;
        end else if (state_q == INIT) begin
            csb_d  = 1'b0;
            web_d  = 1'b0;
            addr_d = clr_cnt_q;
            din_d  = '0;
        end else if (|grant) begin
            csb_d  = 1'b0;
            web_d  = ~sel_we;
            addr_d = sel_addr;
            din_d  = sel_din;
        end
    end

    assign sram_csb  = csb_d;
    assign sram_web  = web_d;
    assign sram_addr = addr_d;
    assign sram_din  = din_d;

    always_comb begin
        tag_d     = '0;
        tag_d.vld = (|grant) && !sel_we;
        tag_d.id  = sel_b ? PORT_B : PORT_A;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RESET_STATE;
            clr_cnt_q <= '0;
        end else if (state_q == INIT) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) begin
                state_q <= RUN;
            end
        end
    end

    // Reset drops any reads in flight by clearing the tag pipe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            din_q  <= '0;
            tag_q  <= '0;
        end else begin
            addr_q <= addr_d;
            din_q  <= din_d;
            tag_q  <= {tag_q[RSP_LATENCY-2:0], tag_d};
        end
    end

    // NOTE: read-data registers are pure datapath and need no reset; rsp_valid qualifies them.
    always_ff @(posedge clk) begin
        if (rst_n && tag_q[0].vld) begin
            if (tag_q[0].id == PORT_A) begin
                a_rdata_q <= sram_dout;
            end else begin
                b_rdata_q <= sram_dout;
            end
        end
    end

    assign a_rsp_valid = rst_n && tag_q[RSP_LATENCY-1].vld && (tag_q[RSP_LATENCY-1].id == PORT_A);
    assign b_rsp_valid = rst_n && tag_q[RSP_LATENCY-1].vld && (tag_q[RSP_LATENCY-1].id == PORT_B);
    assign a_rsp_rdata = a_rdata_q;
    assign b_rsp_rdata = b_rdata_q;

endmodule
